multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle control unit for the 4-bit-opcode processor; successor to the single-cycle decoder.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, waits on a memory ready
//  handshake with timeout, supports a pipeline hold, and latches HALT. Sits between IR and datapath.
// PARAMETERS
//  OPCODE_W     4   opcode width (>=4); class decoded from opcode[OPCODE_W-1 -: 4], other bits ignored
//  ALUOP_W      2   CtrlUla width; 0=add, 1=sub, other codes reserved (never driven)
//  MEM_TIMEOUT  15  max cycles waiting for mem_ready before error (>=1)
//  TO_W   $clog2(MEM_TIMEOUT+1)  timeout counter width (localparam)
// PORTS
//  clock        in   1   single clock, rising edge
//  Reset        in   1   asynchronous, active-high
//  opcode       in   OPCODE_W  IR opcode field, sampled in DECODE
//  zero         in   1   ALU zero flag, sampled in EXEC for beq
//  mem_ready    in   1   memory access complete this cycle
//  hold         in   1   freeze FSM: state/counter held, strobes forced 0
//  IREsc, PCEsc, MemRead, MemWrite, EscReg  out 1  strobes
//  RegFonte, RegOrdem2, PCouSalto, SaltoGeral, Branch, UlaFonte1  out 1  datapath selects
//  RegOrdem1, RegOrdem3, ExtensorSinal, UlaFonte2  out 2  datapath selects
//  CtrlUla      out  ALUOP_W  ALU operation
//  halted       out  1   in HALT;  mem_err  out 1  sticky timeout flag;  state_o  out 3  current state
// BEHAVIOUR
//  - Reset asserted (any cycle, mid-instruction too): state=FETCH, opcode reg=0, counter=0,
//    mem_err=0; all outputs 0 while Reset high. No output is ever z/x.
//  - States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5 ERR=6. Moore outputs from state+latched class.
//  - FETCH: MemRead=1; on mem_ready: IREsc=1, PCEsc=1, PCouSalto=1, ->DECODE. DECODE latches class.
//  - DECODE: halt->HALT; else ->EXEC. EXEC: lw/sw->MEM; set/add/subi->WB; beq/j->FETCH.
//  - MEM: lw MemRead=1 / sw MemWrite=1; on mem_ready lw->WB, sw->FETCH. WB: EscReg=1 for one cycle ->FETCH.
//  - Cycles w/ mem_ready immediate: beq/j 3, sw/set/add/subi 4, lw 5.
//  - EXEC PC update: j PCEsc=1; beq PCEsc=zero; others PCEsc=0.
//  - Class decode (4 MSBs): 111x set, 10xx lw, 01xx sw, 0000 beq, 0001 add, 0010 subi,
//    110x j, 0011 halt. Encoding is complete; no illegal opcodes.
//  - Selects valid DECODE..last state, 0 in FETCH (except PCouSalto=1), HALT, ERR:
//    cls  RegFonte EscReg RegOrdem1 RegOrdem2 RegOrdem3 ExtSinal PCouSalto SaltoGer Branch UF1 UF2 ALU
//    set  1 1 00 0 10 00 1 0 0 0 01 add | lw  0 1 01 0 01 10 1 0 0 1 10 add
//    sw   0 0 01 0 01 10 1 0 0 1 10 add | beq 0 0 00 1 00 00 0 1 1 0 10 sub
//    add  1 1 00 1 00 00 1 0 0 0 10 add | subi 1 1 10 0 11 10 1 0 0 1 10 sub
//    j    0 0 00 0 00 01 0 1 0 0 00 add | halt all 0
//    (EscReg column = write class; EscReg strobe asserted only in WB.)
//  - Timeout: counter clears on state entry, increments each non-hold FETCH/MEM cycle without
//    mem_ready; reaching MEM_TIMEOUT -> ERR, mem_err=1. mem_ready in same cycle wins over timeout.
//  - HALT and ERR absorbing until Reset; halted=1 in HALT only.
//  - hold=1: no transition, counter frozen, strobes 0, selects unchanged; hold beats mem_ready.
// STRUCTURE
//  - Package ctrl_pkg: state encoding, class enum (SET,LW,SW,BEQ,ADD,SUBI,J,HALT),
//    ALU op constants, packed control-word type.
//  - Sub-module ctrl_decode: combinational class -> control word (table above).
//  - Top: FSM, opcode/class register, timeout counter, strobe gating.
// TESTING
//  1 Reset, opcode=0001, mem_ready=1 -> states 0,1,2,4,0; EscReg=1 only in WB; CtrlUla=0.
//  2 opcode=1000 (lw), mem_ready low 3 cycles in MEM -> MEM held 4 cycles, WB then FETCH.
//  3 opcode=0000, zero=1 then zero=0 -> PCEsc=1 / 0 in EXEC, Branch=1, CtrlUla=1, 3 cycles.
//  4 mem_ready never in FETCH -> ERR after 15 cycles, mem_err=1 until Reset.
//  5 opcode=0011 -> HALT, halted=1 stays; hold=1 in MEM for 5 cycles -> no strobes, resumes.
//  6 Reset pulsed mid-MEM of sw -> immediately FETCH, MemWrite=0, all outputs 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle control unit: FSM states, instruction classes,
// ALU operation codes and the packed datapath control word.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_SET,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_ADD,
        CLS_SUBI,
        CLS_J,
        CLS_HALT
    } cls_t;

    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_SUB = 1;

    typedef struct packed {
        logic       reg_fonte;
        logic       esc_reg;
        logic [1:0] reg_ordem1;
        logic       reg_ordem2;
        logic [1:0] reg_ordem3;
        logic [1:0] ext_sinal;
        logic       pc_ou_salto;
        logic       salto_geral;
        logic       branch;
        logic       ula_fonte1;
        logic [1:0] ula_fonte2;
        logic       alu_sub;
    } ctrl_word_t;

    localparam int unsigned CW_W = $bits(ctrl_word_t);

    // Only the four class bits of the opcode are ever passed in.
    function automatic cls_t decode_class(input logic [3:0] op);
        cls_t c;
        casez (op)
            4'b111?: c = CLS_SET;
            4'b110?: c = CLS_J;
            4'b10??: c = CLS_LW;
            4'b01??: c = CLS_SW;
            4'b0000: c = CLS_BEQ;
            4'b0001: c = CLS_ADD;
            4'b0010: c = CLS_SUBI;
            default: c = CLS_HALT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction-class decoder: class bits -> class and datapath control word.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0]      op,
    output logic [2:0]      cls,
    output logic [CW_W-1:0] cw
);

    cls_t       c;
    ctrl_word_t w;

    // Field order: RegFonte EscReg RO1 RO2 RO3 Ext PCouSalto SaltoGer Branch UF1 UF2 sub
    always_comb begin
        c = decode_class(op);
        w = '0;
        case (c)
            CLS_SET:  w = {1'b1, 1'b1, 2'b00, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
            CLS_LW:   w = {1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0};
            CLS_SW:   w = {1'b0, 1'b0, 2'b01, 1'b0, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0};
            CLS_BEQ:  w = {1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1};
            CLS_ADD:  w = {1'b1, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
            CLS_SUBI: w = {1'b1, 1'b1, 2'b10, 1'b0, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1};
            CLS_J:    w = {1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
            default:  w = '0;
        endcase
        cls = c;
        cw  = w;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready
// timeout, pipeline hold, latched HALT and sticky error state.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    input  logic                hold,
    output logic                IREsc,
    output logic                PCEsc,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                EscReg,
    output logic                RegFonte,
    output logic                RegOrdem2,
    output logic                PCouSalto,
    output logic                SaltoGeral,
    output logic                Branch,
    output logic                UlaFonte1,
    output logic [1:0]          RegOrdem1,
    output logic [1:0]          RegOrdem3,
    output logic [1:0]          ExtensorSinal,
    output logic [1:0]          UlaFonte2,
    output logic [ALUOP_W-1:0]  CtrlUla,
    output logic                halted,
    output logic                mem_err,
    output logic [2:0]          state_o
);

    localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

    state_t          state, state_n;
    logic [3:0]      op_q, op_n;
    logic [TO_W-1:0] cnt, cnt_n;
    logic            mem_err_q, mem_err_n;
    logic [3:0]      cls_bits;
    logic [2:0]      cls_raw;
    logic [CW_W-1:0] cw_raw;
    cls_t            cls;
    ctrl_word_t      cw;
    logic            timeout;

    // DECODE works from the live IR; later states use the class latched on leaving DECODE.
    assign cls_bits = (state == ST_DECODE) ? opcode[OPCODE_W-1 -: 4] : op_q;

    ctrl_decode u_decode (
        .op  (cls_bits),
        .cls (cls_raw),
        .cw  (cw_raw)
    );

    assign cls     = cls_t'(cls_raw);
    assign cw      = ctrl_word_t'(cw_raw);
    assign timeout = (cnt == TO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_FETCH;
            op_q      <= '0;
            cnt       <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_n;
            op_q      <= op_n;
            cnt       <= cnt_n;
            mem_err_q <= mem_err_n;
        end
    end

    always_comb begin
        state_n   = state;
        op_n      = op_q;
        cnt_n     = cnt;
        mem_err_n = mem_err_q;
        if (!hold) begin
            case (state)
                ST_FETCH, ST_MEM: begin
                    // mem_ready in the final allowed cycle still completes the access
                    if (mem_ready) begin
                        cnt_n = '0;
                        if (state == ST_FETCH)
                            state_n = ST_DECODE;
                        else if (cls == CLS_LW)
                            state_n = ST_WB;
                        else
                            state_n = ST_FETCH;
                    end else if (timeout) begin
                        cnt_n     = '0;
                        state_n   = ST_ERR;
                        mem_err_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_DECODE: begin
                    op_n    = cls_bits;
                    state_n = (cls == CLS_HALT) ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: begin
                    case (cls)
                        CLS_LW, CLS_SW: state_n = ST_MEM;
                        CLS_BEQ, CLS_J: state_n = ST_FETCH;
                        CLS_HALT:       state_n = ST_HALT;
                        default:        state_n = ST_WB;
                    endcase
                end
                ST_WB:   state_n = ST_FETCH;
                default: state_n = state;
            endcase
        end
    end

    always_comb begin
        IREsc         = 1'b0;
        PCEsc         = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        EscReg        = 1'b0;
        RegFonte      = 1'b0;
        RegOrdem2     = 1'b0;
        PCouSalto     = 1'b0;
        SaltoGeral    = 1'b0;
        Branch        = 1'b0;
        UlaFonte1     = 1'b0;
        RegOrdem1     = '0;
        RegOrdem3     = '0;
        ExtensorSinal = '0;
        UlaFonte2     = '0;
        CtrlUla       = '0;
        halted        = 1'b0;
        mem_err       = 1'b0;
        state_o       = '0;
        if (!Reset) begin
            if (state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
                RegFonte      = cw.reg_fonte;
                RegOrdem1     = cw.reg_ordem1;
                RegOrdem2     = cw.reg_ordem2;
                RegOrdem3     = cw.reg_ordem3;
                ExtensorSinal = cw.ext_sinal;
                PCouSalto     = cw.pc_ou_salto;
                SaltoGeral    = cw.salto_geral;
                Branch        = cw.branch;
                UlaFonte1     = cw.ula_fonte1;
                UlaFonte2     = cw.ula_fonte2;
                CtrlUla       = cw.alu_sub ? ALUOP_W'(ALU_SUB) : ALUOP_W'(ALU_ADD);
            end
            if (state == ST_FETCH)
                PCouSalto = 1'b1;
            if (!hold) begin
                case (state)
                    ST_FETCH: begin
                        MemRead = 1'b1;
                        IREsc   = mem_ready;
                        PCEsc   = mem_ready;
                    end
                    ST_EXEC:  PCEsc    = (cls == CLS_J) || ((cls == CLS_BEQ) && zero);
                    ST_MEM: begin
                        MemRead  = (cls == CLS_LW);
                        MemWrite = (cls == CLS_SW);
                    end
                    ST_WB:    EscReg   = cw.esc_reg;
                    default:  ;
                endcase
            end
            halted  = (state == ST_HALT);
            mem_err = mem_err_q;
            state_o = state;
        end
    end

endmodule
